// File: rtl/ysyx_23060111_mc_ctrl.sv
// Multi-cycle core controller. It sequences fetch, execute, memory and
// write-back phases, counts retired instructions and stops the core on an
// invalid opcode, an ebreak, a bus timeout or a misaligned next pc.
module ysyx_23060111_mc_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned     TMO      = 255
) (
  input  logic            clk,
  input  logic            rst,

  // Instruction fetch
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_resp_valid,
  input  logic [31:0]     ifu_resp_data,
  output logic [31:0]     inst,

  // Decode / execute
  input  logic            dec_inv,
  input  logic            dec_ebreak,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic [XLEN-1:0] exu_dnpc,
  input  logic            rf_wen_in,
  output logic            rf_wen,

  // Load / store
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_resp_valid,

  // Status
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic [31:0]     retire_cnt,
  output logic            halted,
  output logic            inv_flag,
  output logic            bus_err
);

  typedef enum logic [2:0] {
    StFetchReq,
    StFetchWait,
    StExec,
    StMemReq,
    StMemWait,
    StWb,
    StHalt
  } state_e;

  localparam logic [8:0] TmoLim = TMO[8:0];

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [31:0]     retire_cnt_q;
  logic [7:0]      wait_cnt_q;
  logic            inv_q;
  logic            err_q;
  logic            halted_q;

  logic            tmo_hit;
  logic            dnpc_misaligned;

  // wait_cnt_q holds the cycles already spent in this phase; the current
  // cycle is the (wait_cnt_q + 1)-th, so TMO cycles without a handshake expire.
  assign tmo_hit         = ({1'b0, wait_cnt_q} + 9'd1) >= TmoLim;
  assign dnpc_misaligned = exu_dnpc[1:0] != 2'b00;

  // Controller state, architectural registers and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFetchReq;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      retire_cnt_q <= 32'd0;
      wait_cnt_q   <= 8'd0;
      inv_q        <= 1'b0;
      err_q        <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StFetchReq: begin
          if (ifu_req_ready) begin
            state_q    <= StFetchWait;
            wait_cnt_q <= 8'd0;
          end else if (tmo_hit) begin
            state_q    <= StHalt;
            err_q      <= 1'b1;
            halted_q   <= 1'b1;
            wait_cnt_q <= 8'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        StFetchWait: begin
          if (ifu_resp_valid) begin
            inst_q     <= ifu_resp_data;
            state_q    <= StExec;
            wait_cnt_q <= 8'd0;
          end else if (tmo_hit) begin
            state_q    <= StHalt;
            err_q      <= 1'b1;
            halted_q   <= 1'b1;
            wait_cnt_q <= 8'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        StExec: begin
          wait_cnt_q <= 8'd0;
          if (dec_inv) begin
            state_q  <= StHalt;
            inv_q    <= 1'b1;
            halted_q <= 1'b1;
          end else if (dec_ebreak) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (dec_load || dec_store) begin
            state_q <= StMemReq;
          end else begin
            state_q <= StWb;
          end
        end

        StMemReq: begin
          if (lsu_req_ready) begin
            state_q    <= StMemWait;
            wait_cnt_q <= 8'd0;
          end else if (tmo_hit) begin
            state_q    <= StHalt;
            err_q      <= 1'b1;
            halted_q   <= 1'b1;
            wait_cnt_q <= 8'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        StMemWait: begin
          if (lsu_resp_valid) begin
            state_q    <= StWb;
            wait_cnt_q <= 8'd0;
          end else if (tmo_hit) begin
            state_q    <= StHalt;
            err_q      <= 1'b1;
            halted_q   <= 1'b1;
            wait_cnt_q <= 8'd0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        StWb: begin
          // The instruction still commits on a misaligned target; only the
          // pc update is suppressed and the core stops afterwards.
          wait_cnt_q   <= 8'd0;
          retire_cnt_q <= retire_cnt_q + 32'd1;
          if (dnpc_misaligned) begin
            state_q  <= StHalt;
            err_q    <= 1'b1;
            halted_q <= 1'b1;
          end else begin
            pc_q    <= exu_dnpc;
            state_q <= StFetchReq;
          end
        end

        StHalt: begin
          wait_cnt_q <= 8'd0;
        end

        default: begin
          state_q  <= StHalt;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // Phase-owned strobes, held low while reset is asserted.
  always_comb begin
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rf_wen        = 1'b0;
    retire        = 1'b0;
    if (!rst) begin
      ifu_req_valid = state_q == StFetchReq;
      lsu_req_valid = state_q == StMemReq;
      rf_wen        = (state_q == StWb) && rf_wen_in;
      retire        = state_q == StWb;
    end
  end

  assign ifu_addr   = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign retire_cnt = retire_cnt_q;
  assign halted     = halted_q;
  assign inv_flag   = inv_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_ysyx_23060111_mc_ctrl.sv
// Bench for ysyx_23060111_mc_ctrl: a phase/dwell reference model checked
// every cycle, directed scenarios with literal expectations, then random runs.
module tb_ysyx_23060111_mc_ctrl;

  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_resp_data, inst;
  logic        dec_inv, dec_ebreak, dec_load, dec_store;
  logic [31:0] exu_dnpc;
  logic        rf_wen_in, rf_wen;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic [31:0] pc, retire_cnt;
  logic        retire, halted, inv_flag, bus_err;

  always #5 clk = ~clk;

  ysyx_23060111_mc_ctrl #(
    .XLEN    (XLEN),
    .RESET_PC(RST_PC),
    .TMO     (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data (ifu_resp_data),
    .inst          (inst),
    .dec_inv       (dec_inv),
    .dec_ebreak    (dec_ebreak),
    .dec_load      (dec_load),
    .dec_store     (dec_store),
    .exu_dnpc      (exu_dnpc),
    .rf_wen_in     (rf_wen_in),
    .rf_wen        (rf_wen),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid),
    .pc            (pc),
    .retire        (retire),
    .retire_cnt    (retire_cnt),
    .halted        (halted),
    .inv_flag      (inv_flag),
    .bus_err       (bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which phase the core is in and how long it has been there.
  localparam int PFreq = 0, PFwait = 1, PExec = 2, PMreq = 3, PMwait = 4, PWb = 5, PHalt = 6;
  int          m_phase, m_dwell;
  logic [31:0] m_pc, m_inst, m_cnt;
  logic        m_inv, m_berr;

  function automatic logic [31:0] b(input logic x);
    return {31'd0, x};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PFreq;
    m_dwell = 0;
    m_pc    = RST_PC;
    m_inst  = 32'd0;
    m_cnt   = 32'd0;
    m_inv   = 1'b0;
    m_berr  = 1'b0;
  endtask

  // A waiting phase advances on its handshake, else dies on its TMO-th cycle.
  task automatic wait_phase(input logic hs, input int nxt_ok, inout int nxt);
    if (hs) nxt = nxt_ok;
    else if (m_dwell + 1 >= TMO) begin
      m_berr = 1'b1;
      nxt    = PHalt;
    end
  endtask

  task automatic model_step();
    int nxt;
    nxt = m_phase;
    case (m_phase)
      PFreq:  wait_phase(ifu_req_ready, PFwait, nxt);
      PFwait: begin
        if (ifu_resp_valid) m_inst = ifu_resp_data;
        wait_phase(ifu_resp_valid, PExec, nxt);
      end
      PExec: begin
        if (dec_inv) begin
          m_inv = 1'b1;
          nxt   = PHalt;
        end else if (dec_ebreak) nxt = PHalt;
        else if (dec_load || dec_store) nxt = PMreq;
        else nxt = PWb;
      end
      PMreq:  wait_phase(lsu_req_ready, PMwait, nxt);
      PMwait: wait_phase(lsu_resp_valid, PWb, nxt);
      PWb: begin
        m_cnt = m_cnt + 32'd1;
        if (exu_dnpc[1:0] != 2'b00) begin
          m_berr = 1'b1;
          nxt    = PHalt;
        end else begin
          m_pc = exu_dnpc;
          nxt  = PFreq;
        end
      end
      default: ;
    endcase
    m_dwell = (nxt == m_phase) ? m_dwell + 1 : 0;
    m_phase = nxt;
  endtask

  task automatic compare();
    logic en;
    en = !rst;
    chk("ifu_req_valid", b(ifu_req_valid), b(en && m_phase == PFreq));
    chk("lsu_req_valid", b(lsu_req_valid), b(en && m_phase == PMreq));
    chk("rf_wen",        b(rf_wen),        b(en && m_phase == PWb && rf_wen_in));
    chk("retire",        b(retire),        b(en && m_phase == PWb));
    chk("ifu_addr",      ifu_addr,         m_pc);
    chk("pc",            pc,               m_pc);
    chk("inst",          inst,             m_inst);
    chk("retire_cnt",    retire_cnt,       m_cnt);
    chk("halted",        b(halted),        b(m_phase == PHalt));
    chk("inv_flag",      b(inv_flag),      b(m_inv));
    chk("bus_err",       b(bus_err),       b(m_berr));
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 1 ns later.
  task automatic sample();
    #1;
    if (rst) model_reset();
    compare();
  endtask

  task automatic advance();
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_data  = 32'd0;
    dec_inv        = 1'b0;
    dec_ebreak     = 1'b0;
    dec_load       = 1'b0;
    dec_store      = 1'b0;
    exu_dnpc       = 32'd0;
    rf_wen_in      = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    sample();
    chk("reset_pc",  pc, RST_PC);
    chk("reset_cnt", retire_cnt, 32'd0);
    advance();
    rst = 1'b0;
  endtask

  task automatic fast_bus();
    ifu_req_ready  = 1'b1;
    ifu_resp_valid = 1'b1;
    ifu_resp_data  = 32'h0050_0093;  // addi x1, x0, 5
    lsu_req_ready  = 1'b1;
    lsu_resp_valid = 1'b1;
    rf_wen_in      = 1'b1;
    exu_dnpc       = m_pc + 32'd4;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nret, nwen, nlsu;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);

    // Back-to-back addi with single-cycle handshakes.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      fast_bus();
      sample();
      if (c == 2) chk("t1_no_retire_c2", b(retire), 32'd0);
      if (c == 3) chk("t1_retire_c3", b(retire), 32'd1);
      if (c == 4) chk("t1_pc_c4", pc, 32'h8000_0004);
      if (c == 7) chk("t1_retire_c7", b(retire), 32'd1);
      if (c == 8) begin
        chk("t1_cnt_c8", retire_cnt, 32'd2);
        chk("t1_pc_c8", pc, 32'h8000_0008);
      end
      advance();
    end

    // Load with a slow memory: ready on the 4th request cycle, resp on the 3rd wait cycle.
    do_reset();
    nret = 0; nwen = 0; nlsu = 0;
    for (int c = 0; c <= 10; c++) begin
      fast_bus();
      dec_load       = 1'b1;
      lsu_req_ready  = (m_phase == PMreq) && (m_dwell == 3);
      lsu_resp_valid = (m_phase == PMwait) && (m_dwell == 2);
      sample();
      nret += int'(retire);
      nwen += int'(rf_wen);
      nlsu += int'(lsu_req_valid);
      if (c == 10) chk("t2_retire_c10", b(retire), 32'd1);
      advance();
    end
    chk("t2_lsu_req_cycles", nlsu, 32'd4);
    chk("t2_rf_wen_pulses", nwen, 32'd1);
    chk("t2_retires", nret, 32'd1);

    // Invalid opcode beats ebreak.
    do_reset();
    nret = 0;
    for (int c = 0; c <= 5; c++) begin
      fast_bus();
      dec_inv    = 1'b1;
      dec_ebreak = 1'b1;
      sample();
      nret += int'(retire);
      if (c == 2) chk("t3_not_halted_c2", b(halted), 32'd0);
      if (c == 3) begin
        chk("t3_halted_c3", b(halted), 32'd1);
        chk("t3_inv_c3", b(inv_flag), 32'd1);
      end
      advance();
    end
    chk("t3_retires", nret, 32'd0);
    chk("t3_pc", pc, RST_PC);

    // Fetch response never arrives: timeout after TMO cycles in fetch-wait.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      fast_bus();
      ifu_resp_valid = 1'b0;
      sample();
      if (c == 4) chk("t4a_not_halted_c4", b(halted), 32'd0);
      if (c == 5) begin
        chk("t4a_halted_c5", b(halted), 32'd1);
        chk("t4a_bus_err_c5", b(bus_err), 32'd1);
      end
      advance();
    end

    // Response on the last allowed cycle wins.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      fast_bus();
      ifu_resp_valid = (c == 4);
      sample();
      if (c == 5) begin
        chk("t4b_no_err_c5", b(bus_err), 32'd0);
        chk("t4b_inst_c5", inst, 32'h0050_0093);
      end
      if (c == 6) chk("t4b_retire_c6", b(retire), 32'd1);
      advance();
    end

    // Misaligned next pc.
    do_reset();
    nret = 0;
    for (int c = 0; c <= 7; c++) begin
      fast_bus();
      exu_dnpc = 32'h8000_0006;
      sample();
      nret += int'(retire);
      advance();
    end
    chk("t5_retires", nret, 32'd1);
    chk("t5_pc", pc, 32'h8000_0000);
    chk("t5_bus_err", b(bus_err), 32'd1);
    chk("t5_halted", b(halted), 32'd1);
    chk("t5_cnt", retire_cnt, 32'd1);

    // Counter wrap, then reset while waiting on memory.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      fast_bus();
      dec_load       = (c >= 4);
      lsu_resp_valid = 1'b0;
      if (c == 2) begin
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
      end
      if (c == 3) release dut.retire_cnt_q;
      rst = (c == 9);
      sample();
      if (c == 4) begin
        chk("t6_wrap_cnt", retire_cnt, 32'd0);
        chk("t6_pc_c4", pc, 32'h8000_0004);
      end
      if (c == 8) chk("t6_in_mem_wait", b(lsu_req_valid), 32'd0);
      if (c == 9) begin
        chk("t6_rst_pc", pc, 32'h8000_0000);
        chk("t6_rst_cnt", retire_cnt, 32'd0);
        chk("t6_rst_rf_wen", b(rf_wen), 32'd0);
        chk("t6_rst_retire", b(retire), 32'd0);
      end
      if (c == 10) chk("t6_fetch_after_rst", b(ifu_req_valid), 32'd1);
      advance();
    end
    rst = 1'b0;

    // Random traffic, occasional mid-run resets.
    for (int seg = 0; seg < 40; seg++) begin
      int p;
      p = int'($urandom_range(100, 35));
      do_reset();
      for (int c = 0; c < 150; c++) begin
        ifu_req_ready  = $urandom_range(99) < p;
        ifu_resp_valid = $urandom_range(99) < p;
        ifu_resp_data  = $urandom;
        lsu_req_ready  = $urandom_range(99) < p;
        lsu_resp_valid = $urandom_range(99) < p;
        dec_inv        = $urandom_range(39) == 0;
        dec_ebreak     = $urandom_range(39) == 0;
        dec_load       = $urandom_range(3) == 0;
        dec_store      = $urandom_range(3) == 0;
        rf_wen_in      = $urandom_range(1) == 1;
        case ($urandom_range(15))
          0:       exu_dnpc = m_pc + 32'(1 + $urandom_range(2));
          1:       exu_dnpc = {$urandom, 2'b00} >> 2 << 2;
          default: exu_dnpc = m_pc + 32'd4;
        endcase
        rst = $urandom_range(99) == 0;
        sample();
        advance();
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060111_mc_ctrl.md
YSYX_23060111_MC_CTRL -- requirements
Module: ysyx_23060111_mc_ctrl

Interface
REQ-001 SHALL take parameter XLEN, default 32, data/address width.
REQ-002 SHALL take parameter RESET_PC, default 32'h8000_0000, PC value after reset.
REQ-003 SHALL take parameter TMO, default 255, maximum wait cycles per bus phase (1..255).
REQ-004 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  out  1  fetch request.
- ifu_req_ready  in  1  fetch accepted.
- ifu_addr  out  XLEN  fetch address, equal to pc.
- ifu_resp_valid  in  1  fetch data valid.
- ifu_resp_data  in  32  fetched instruction.
- inst  out  32  latched instruction.
- dec_inv  in  1  invalid opcode.
- dec_ebreak  in  1  ebreak decoded.
- dec_load  in  1  load decoded.
- dec_store  in  1  store decoded.
- exu_dnpc  in  XLEN  next pc from EXU.
- rf_wen_in  in  1  EXU register-write request.
- rf_wen  out  1  gated register-file write enable.
- lsu_req_valid  out  1  memory request.
- lsu_req_ready  in  1  memory request accepted.
- lsu_resp_valid  in  1  memory completion.
- pc  out  XLEN  current pc.
- retire  out  1  one-cycle pulse per committed instruction.
- retire_cnt  out  32  committed-instruction counter.
- halted  out  1  core stopped.
- inv_flag  out  1  sticky invalid-instruction flag.
- bus_err  out  1  sticky timeout/misalign flag.

Function
REQ-005 SHALL implement states FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB and HALT, encoded in one registered state variable.
REQ-006 FETCH_REQ SHALL drive ifu_req_valid=1 and SHALL move to FETCH_WAIT on the cycle ifu_req_ready=1.
REQ-007 FETCH_WAIT SHALL latch ifu_resp_data into inst and move to EXEC on the cycle ifu_resp_valid=1; inst SHALL hold its value in all other states.
REQ-008 EXEC SHALL last exactly one cycle, with next-state priority: dec_inv -> HALT (set inv_flag); else dec_ebreak -> HALT; else dec_load|dec_store -> MEM_REQ; else -> WB.
REQ-009 MEM_REQ SHALL drive lsu_req_valid=1 and move to MEM_WAIT on lsu_req_ready=1; MEM_WAIT SHALL move to WB on lsu_resp_valid=1; loads and stores both wait for the response.
REQ-010 WB SHALL last one cycle and SHALL drive rf_wen=rf_wen_in and retire=1; it SHALL load pc<=exu_dnpc, increment retire_cnt (modulo 2^32, wrapping 0xFFFF_FFFF->0), and go to FETCH_REQ.
REQ-011 rf_wen, retire, ifu_req_valid and lsu_req_valid SHALL be 0 outside their owning state.
REQ-012 In WB, if exu_dnpc[1:0]!=0, pc SHALL NOT update, rf_wen SHALL still follow rf_wen_in, retire SHALL pulse, bus_err SHALL set, and the next state SHALL be HALT.
REQ-013 A wait counter (8 bits) SHALL clear on every state change and increment each cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT; when it equals TMO with no handshake that cycle, the block SHALL set bus_err and go to HALT.
REQ-014 A handshake arriving in the same cycle the counter reaches TMO SHALL win; no error is raised.
REQ-015 Early response SHALL be ignored: ifu_resp_valid outside FETCH_WAIT and lsu_resp_valid outside MEM_WAIT have no effect.
REQ-016 HALT SHALL be absorbing: halted=1, all request and write outputs 0, pc, inst, retire_cnt and the flags frozen until reset.
REQ-017 Latency: a non-memory instruction with single-cycle ready/resp SHALL retire 4 cycles after entering FETCH_REQ (FETCH_REQ, FETCH_WAIT, EXEC, WB); a memory instruction SHALL take 6.

Reset
REQ-018 While rst=1, the block SHALL asynchronously force state=FETCH_REQ, pc=RESET_PC, inst=0, retire_cnt=0, wait counter=0, inv_flag=0, bus_err=0 and halted=0.
REQ-019 While rst=1, all request, rf_wen and retire outputs SHALL be 0; FETCH_REQ behaviour begins on the first rising edge after deassertion.
REQ-020 Reset asserted mid-transaction (any state, including HALT) SHALL abandon the transaction with no retire pulse and no register write.

Verification
REQ-021 Reset, ready/resp always 1, inst=addi, rf_wen_in=1, exu_dnpc=pc+4 -> retire every 4 cycles, pc 0x8000_0000 -> 0x8000_0004 -> 0x8000_0008, retire_cnt=2 after 8 cycles.
REQ-022 dec_load=1, lsu_req_ready delayed 3 cycles, lsu_resp_valid delayed 2 -> MEM_REQ held 4 cycles, one rf_wen pulse, retire 11 cycles after start.
REQ-023 dec_inv=1 together with dec_ebreak=1 -> HALT next cycle, inv_flag=1, retire never pulses, pc unchanged.
REQ-024 TMO=4, ifu_resp_valid held 0 -> bus_err=1 and halted=1 after 4 cycles in FETCH_WAIT; with resp arriving on cycle 4 -> no error, EXEC follows.
REQ-025 exu_dnpc=0x8000_0006 -> retire pulses once, pc stays 0x8000_0000, bus_err=1, halted=1.
REQ-026 Preload retire_cnt near wrap (force 0xFFFF_FFFF) then one retire -> 0; rst pulsed in MEM_WAIT -> pc=0x8000_0000, retire_cnt=0, no rf_wen.
